regfile_write_demux: RTL and testbench
======================================

# regfile_write_demux

Write-side counterpart of the register file's read-select multiplexers: accepts writeback requests carrying a 5-bit register number and 64-bit data, buffers them in a 2-entry queue, and drives a registered one-hot write-enable vector plus data into the 32×64 register array. It sits between the writeback pipeline stage and the register array. It also exports a per-register pending-write vector, which hazard logic uses to detect buffered writes that have not yet landed.

## Interface
- NREGS, 32, number of architectural registers; one-hot output width
- AW, 5, register address width (log2 NREGS)
- DW, 64, data width
- DEPTH, 2, write-queue entries
- clk  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wr_valid  in  1  writeback request present
- wr_ready  out  1  queue can accept; equals !full
- wr_addr  in  AW  destination register number
- wr_data  in  DW  data to write
- commit_en  in  1  register array may take a write this cycle
- we_onehot  out  NREGS  registered one-hot write enable; all-zero when idle
- wdata_out  out  DW  registered data, aligned with we_onehot
- pending  out  NREGS  bit i set while a write to register i is queued or in the output register

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Accept: a request is taken on a rising edge when wr_valid && wr_ready.
- XZR handling: a request with wr_addr == 31 (XZR) is accepted normally but discarded; it is never enqueued and never sets pending.
- Queue: circular buffer, DEPTH entries, with a head pointer, tail pointer and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Pop: when count > 0 and commit_en = 1, the head entry is popped. On the same edge, we_onehot <= 1 << head_addr and wdata_out <= head_data.
- Idle output: with no pop, we_onehot <= 0 and wdata_out holds its previous value.
- Simultaneous push and pop: both occur on the same edge; count is unchanged.
- Full: a push is impossible because wr_ready = 0. A pop frees a slot, and wr_ready rises in the following cycle; there is no same-cycle pass-through.
- Empty: commit_en is ignored and we_onehot stays 0.
- Ordering: FIFO order is preserved. Two queued writes to the same register both commit, oldest first.
- pending: combinational OR of the decoded addresses of all valid queue entries, OR'd with the current we_onehot.
- Reset: count, pointers, we_onehot, wdata_out and pending all go to 0, and wr_ready goes to 1, asynchronously. Any request in flight when reset asserts is lost with no partial commit. The first edge after reset deasserts behaves as from empty.

## Timing
- Accept at edge N, queue empty, commit_en = 1 at N+1: we_onehot is valid in the cycle after edge N+1, so minimum latency is 2 cycles.
- we_onehot is asserted for exactly one cycle per committed write.
- Throughput: one write per cycle when commit_en is held high.
- pending: a bit rises the cycle after the accepting edge and falls the cycle after its we_onehot pulse ends.
- wr_ready and pending are combinational from registered state only; there is no combinational path from wr_valid, wr_addr or commit_en to any output.

## Structure
- Package regfile_pkg: NREGS, AW, DW, XZR_ADDR = 31, and the typedefs reg_addr_t and reg_data_t.
- Sub-module decoder5_32: combinational 5-to-32 one-hot decoder. Instantiate one for the head entry and one per queue entry for pending.
- Top level holds the queue registers, pointers, count and output registers.

## Test plan
- Reset mid-operation: enqueue two writes, then assert reset for 1 cycle -> we_onehot = 0, pending = 0, wr_ready = 1 immediately; no write commits after release.
- Single write: wr_addr = 3, wr_data = 64'hDEAD_BEEF, commit_en = 1 -> we_onehot = 32'h0000_0008 and wdata_out = 64'hDEAD_BEEF two cycles after accept, for one cycle; pending[3] high in between.
- XZR: wr_addr = 31, wr_data = 64'h1234 -> accepted; we_onehot stays 0 and pending stays 0.
- Backpressure: commit_en = 0, push addr 1 then addr 2 -> wr_ready = 0 and pending = 32'h0000_0006. Raise commit_en -> we_onehot = 0x2 then 0x4 on consecutive cycles; wr_ready returns to 1 after the first pop.
- Simultaneous events: count = 1 (addr 5 queued), push addr 7 with commit_en = 1 on the same edge -> count stays 1, we_onehot = 0x20, then 0x80 the next cycle.
- Wrap-around: stream 6 writes to addrs 0..5 with commit_en = 1 -> six consecutive one-hot pulses in order, pointers wrap with no loss or duplication.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, types and pointer helper for the register-file write demux.
package regfile_pkg;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int DW    = 64;
   localparam int DEPTH = 2;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef logic [AW-1:0]    reg_addr_t;
   typedef logic [DW-1:0]    reg_data_t;
   typedef logic [NREGS-1:0] reg_vec_t;

   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } wr_req_t;

   localparam reg_addr_t XZR_ADDR = 5'd31;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction
endpackage

// File: rtl/decoder5_32.sv
// Combinational register-number to one-hot decoder.
module decoder5_32
   import regfile_pkg::*;
(
   input  logic [AW-1:0]    i_addr,
   output logic [NREGS-1:0] o_onehot
);

   always_comb begin
      o_onehot         = {NREGS{1'b0}};
      o_onehot[i_addr] = 1'b1;
   end

endmodule

// File: rtl/regfile_write_demux.sv
// Writeback request queue feeding a registered one-hot write port of the
// register array; exports a pending-write vector for hazard detection.
module regfile_write_demux
   import regfile_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [DW-1:0]    i_wr_data,
   input  logic             i_commit_en,
   output logic [NREGS-1:0] o_we_onehot,
   output logic [DW-1:0]    o_wdata_out,
   output logic [NREGS-1:0] o_pending
);

   wr_req_t       r_q [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   reg_vec_t      r_we_onehot;
   reg_data_t     r_wdata;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   reg_vec_t         w_head_onehot;
   reg_vec_t         w_entry_onehot [DEPTH];
   logic [DEPTH-1:0] w_entry_valid;
   reg_vec_t         w_pending;

   assign w_full = (r_count == CW'(DEPTH));
   assign w_pop  = (r_count != {CW{1'b0}}) && i_commit_en;
   // XZR writes are handshaken but dropped before reaching the queue.
   assign w_push = i_wr_valid && !w_full && (i_wr_addr != XZR_ADDR);

   decoder5_32 u_head_dec (
      .i_addr   (r_q[r_head].addr),
      .o_onehot (w_head_onehot)
   );

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      decoder5_32 u_dec (
         .i_addr   (r_q[g].addr),
         .o_onehot (w_entry_onehot[g])
      );
      // Slot g is live when its distance from head is below the occupancy.
      assign w_entry_valid[g] =
         ((CW'(g) + ((PW'(g) < r_head) ? CW'(DEPTH) : {CW{1'b0}}) - CW'(r_head)) < r_count);
   end

   always_comb begin
      w_pending = r_we_onehot;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_entry_valid[i]) begin
            w_pending = w_pending | w_entry_onehot[i];
         end else begin
            w_pending = w_pending;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i] <= '{addr: {AW{1'b0}}, data: {DW{1'b0}}};
         end
      end else if (w_push) begin
         r_q[r_tail] <= '{addr: i_wr_addr, data: i_wr_data};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head  <= {PW{1'b0}};
         r_tail  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_pop) r_head <= ptr_inc(r_head);
         if (w_push) r_tail <= ptr_inc(r_tail);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Write port: one-cycle pulse per pop, data held between pops.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_we_onehot <= {NREGS{1'b0}};
         r_wdata     <= {DW{1'b0}};
      end else if (w_pop) begin
         r_we_onehot <= w_head_onehot;
         r_wdata     <= r_q[r_head].data;
      end else begin
         r_we_onehot <= {NREGS{1'b0}};
      end
   end

   assign o_wr_ready  = !w_full;
   assign o_we_onehot = r_we_onehot;
   assign o_wdata_out = r_wdata;
   assign o_pending   = w_pending;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed bench for regfile_write_demux: queue-based reference model checked
// every negedge, plus hand-computed literal expectations per scenario.
module tb_regfile_write_demux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [63:0] wr_data = 64'd0;
   logic        commit_en = 1'b0;
   logic        wr_ready;
   logic [31:0] we_onehot;
   logic [63:0] wdata_out;
   logic [31:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [68:0] m_q[$];
   logic [31:0] m_we = 32'd0;
   logic [63:0] m_wdata = 64'd0;

   logic        lit_en = 1'b0;
   logic        lit_wd_en = 1'b0;
   logic [31:0] lit_we = 32'd0;
   logic [31:0] lit_pend = 32'd0;
   logic        lit_rdy = 1'b1;
   logic [63:0] lit_wd = 64'd0;

   regfile_write_demux dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_wr_valid  (wr_valid),
      .o_wr_ready  (wr_ready),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_commit_en (commit_en),
      .o_we_onehot (we_onehot),
      .o_wdata_out (wdata_out),
      .o_pending   (pending)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_pending();
      logic [31:0] r;
      r = m_we;
      foreach (m_q[k]) r = r | (32'd1 << m_q[k][68:64]);
      return r;
   endfunction

   // Reference: what one rising edge does to the queue and the write port.
   task automatic model_step();
      logic        rdy;
      logic [68:0] h;
      if (!rst) begin
         rdy = (m_q.size() < 2);
         if (m_q.size() > 0 && commit_en) begin
            h       = m_q.pop_front();
            m_we    = 32'd1 << h[68:64];
            m_wdata = h[63:0];
         end else begin
            m_we = 32'd0;
         end
         if (wr_valid && rdy && wr_addr != 5'd31) m_q.push_back({wr_addr, wr_data});
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_we    = 32'd0;
      m_wdata = 64'd0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process.
   initial begin
      forever begin
         @(negedge clk);
         chk("model_we", {32'd0, we_onehot}, {32'd0, m_we});
         chk("model_wdata", wdata_out, m_wdata);
         chk("model_pending", {32'd0, pending}, {32'd0, m_pending()});
         chk("model_ready", {63'd0, wr_ready}, {63'd0, (m_q.size() < 2)});
         if (lit_en) begin
            chk("lit_we", {32'd0, we_onehot}, {32'd0, lit_we});
            chk("lit_pending", {32'd0, pending}, {32'd0, lit_pend});
            chk("lit_ready", {63'd0, wr_ready}, {63'd0, lit_rdy});
         end
         if (lit_wd_en) chk("lit_wdata", wdata_out, lit_wd);
      end
   end

   task automatic expect_lit(input logic [31:0] we, input logic [31:0] pd, input logic rdy);
      lit_en = 1'b1; lit_we = we; lit_pend = pd; lit_rdy = rdy;
   endtask

   task automatic expect_wd(input logic [63:0] d);
      lit_wd_en = 1'b1; lit_wd = d;
   endtask

   task automatic cyc(input logic v, input logic [4:0] a, input logic [63:0] d, input logic c);
      wr_valid = v; wr_addr = a; wr_data = d; commit_en = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      lit_en = 1'b0; lit_wd_en = 1'b0;
   endtask

   initial begin
      // Reset state
      expect_lit(32'd0, 32'd0, 1'b1); expect_wd(64'd0);
      @(negedge clk); #1;
      lit_en = 1'b0; lit_wd_en = 1'b0;
      rst = 1'b0;

      // Single write, two-cycle latency
      expect_lit(32'd0, 32'h8, 1'b1);                            cyc(1'b1, 5'd3, 64'hDEAD_BEEF, 1'b1);
      expect_lit(32'h8, 32'h8, 1'b1); expect_wd(64'hDEAD_BEEF); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      expect_lit(32'd0, 32'd0, 1'b1); expect_wd(64'hDEAD_BEEF); cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // XZR is accepted but discarded
      expect_lit(32'd0, 32'd0, 1'b1);                            cyc(1'b1, 5'd31, 64'h1234, 1'b1);
      expect_lit(32'd0, 32'd0, 1'b1); expect_wd(64'hDEAD_BEEF); cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // Backpressure; push while full is refused
      expect_lit(32'd0, 32'h2, 1'b1);                  cyc(1'b1, 5'd1, 64'h11, 1'b0);
      expect_lit(32'd0, 32'h6, 1'b0);                  cyc(1'b1, 5'd2, 64'h22, 1'b0);
      expect_lit(32'h2, 32'h6, 1'b1); expect_wd(64'h11); cyc(1'b1, 5'd9, 64'h99, 1'b1);
      expect_lit(32'h4, 32'h4, 1'b1); expect_wd(64'h22); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      expect_lit(32'd0, 32'd0, 1'b1);                  cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // Simultaneous push and pop
      expect_lit(32'd0, 32'h20, 1'b1);                   cyc(1'b1, 5'd5, 64'h55, 1'b0);
      expect_lit(32'h20, 32'hA0, 1'b1); expect_wd(64'h55); cyc(1'b1, 5'd7, 64'h77, 1'b1);
      expect_lit(32'h80, 32'h80, 1'b1); expect_wd(64'h77); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      expect_lit(32'd0, 32'd0, 1'b1);                    cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // Same register twice commits oldest first
      cyc(1'b1, 5'd4, 64'hA, 1'b0);
      expect_lit(32'd0, 32'h10, 1'b0);                   cyc(1'b1, 5'd4, 64'hB, 1'b0);
      expect_lit(32'h10, 32'h10, 1'b1); expect_wd(64'hA); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      expect_lit(32'h10, 32'h10, 1'b1); expect_wd(64'hB); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // Wrap-around stream of six writes
      for (int i = 0; i < 6; i++) cyc(1'b1, 5'(i), 64'h100 + 64'(i), 1'b1);
      expect_lit(32'h20, 32'h20, 1'b1); expect_wd(64'h105); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // Reset mid-operation with two writes queued
      cyc(1'b1, 5'd10, 64'hAA, 1'b0);
      cyc(1'b1, 5'd11, 64'hBB, 1'b0);
      wr_valid = 1'b0; commit_en = 1'b0;
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b1;
      model_clear();
      expect_lit(32'd0, 32'd0, 1'b1); expect_wd(64'd0);
      @(negedge clk); #1;
      lit_en = 1'b0; lit_wd_en = 1'b0;
      wr_valid = 1'b1; wr_addr = 5'd12; commit_en = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      expect_lit(32'd0, 32'd0, 1'b1); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      expect_lit(32'd0, 32'd0, 1'b1); cyc(1'b0, 5'd0, 64'd0, 1'b1);

      // First accept after reset behaves as from empty
      expect_lit(32'd0, 32'h40, 1'b1);                   cyc(1'b1, 5'd6, 64'h66, 1'b1);
      expect_lit(32'h40, 32'h40, 1'b1); expect_wd(64'h66); cyc(1'b0, 5'd0, 64'd0, 1'b1);
      cyc(1'b0, 5'd0, 64'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
